// File: rtl/core_feeder_pkg.sv
// Shared definitions for the core feeder: request code, FSM states and default sizing.
package core_feeder_pkg;

  localparam int DEF_NUM_CORES  = 24;
  localparam int DEF_DW         = 19;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_WAIT_MAX   = 16;

  localparam logic [3:0] REQ_SAMPLE = 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/core_feeder_fifo.sv
// Sample buffer for core_feeder: power-of-two circular FIFO with head-of-queue read port.
module feeder_fifo #(
  parameter int DW    = 19,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              wdata,
  input  logic                       pop,
  output logic [DW-1:0]              rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only the pointers and level define contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/core_feeder.sv
// Buffers upstream samples and hands them one at a time to requesting cores,
// round-robin, over a shared io_in bus qualified by a one-hot in_en pulse.
module core_feeder
  import core_feeder_pkg::*;
#(
  parameter int NUM_CORES  = DEF_NUM_CORES,
  parameter int DW         = DEF_DW,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int WAIT_MAX   = DEF_WAIT_MAX
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [DW-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [4*NUM_CORES-1:0]        req_in,
  output logic signed [DW-1:0]          io_in,
  output logic [NUM_CORES-1:0]          in_en,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_timeout,
  output feeder_state_e                 dbg_state
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  feeder_state_e   state_q, state_d;
  logic [IDX_W-1:0] winner_q, rr_ptr_q, pick;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [NUM_CORES-1:0] req_vec;
  logic [DW-1:0]    fifo_rdata;
  logic             fifo_empty;
  logic             ready_en_q;
  logic             any_req;
  logic             grant;
  logic             timeout;
  logic             push;
  int               cand;

  // Upstream handshake: a sample transfers on a rising edge where s_valid && s_ready;
  // s_ready never depends on s_valid.
  assign s_ready   = ready_en_q && (fifo_level < LVL_W'(FIFO_DEPTH));
  assign push      = s_valid && s_ready;
  assign dbg_state = state_q;

  feeder_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (s_data),
    .pop   (grant),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .empty (fifo_empty)
  );

  always_comb begin
    req_vec = '0;
    for (int k = 0; k < NUM_CORES; k++) req_vec[k] = (req_in[4*k +: 4] == REQ_SAMPLE);
  end

  // Round-robin scan starting at rr_ptr; the first requester found wins.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    cand    = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      if (!any_req && req_vec[IDX_W'(cand)]) begin
        any_req = 1'b1;
        pick    = IDX_W'(cand);
      end
    end
  end

  // wait_cnt counts cycles since the grant cycle, so the timeout lands WAIT_MAX cycles after it.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && any_req) begin
          state_d = ST_GRANT;
          grant   = 1'b1;
        end
      end
      ST_GRANT: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!req_vec[winner_q]) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_q == CNT_W'(WAIT_MAX - 1)) begin
          state_d = ST_IDLE;
          timeout = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      winner_q    <= '0;
      rr_ptr_q    <= '0;
      wait_cnt_q  <= '0;
      io_in       <= '0;
      in_en       <= '0;
      err_timeout <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      in_en      <= '0;
      if (grant) begin
        in_en    <= {{(NUM_CORES-1){1'b0}}, 1'b1} << pick;
        io_in    <= fifo_rdata;
        winner_q <= pick;
        rr_ptr_q <= (pick == IDX_W'(NUM_CORES - 1)) ? '0 : pick + IDX_W'(1);
      end
      if (state_q == ST_GRANT)     wait_cnt_q <= CNT_W'(1);
      else if (state_q == ST_WAIT) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      if (timeout) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_feeder.sv
// Directed bench for core_feeder: reset, single grant, non-request code, timeout,
// mid-grant reset, 24-core round robin and full-FIFO hold/drain.
module tb_core_feeder;
  import core_feeder_pkg::*;

  localparam int NC = 24;

  logic                 clk;
  logic                 rst_n;
  logic signed [18:0]   s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic [4*NC-1:0]      req_in;
  logic signed [18:0]   io_in;
  logic [NC-1:0]        in_en;
  logic [4:0]           fifo_level;
  logic                 err_timeout;
  feeder_state_e        dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  core_feeder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .req_in      (req_in),
    .io_in       (io_in),
    .in_en       (in_en),
    .fifo_level  (fifo_level),
    .err_timeout (err_timeout),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [3:0] code);
    req_in[4*k +: 4] = code;
  endtask

  task automatic push(input logic [18:0] v);
    int n = 0;
    s_data  = v;
    s_valid = 1'b1;
    while (!s_ready && n < 60) begin
      tick();
      n++;
    end
    check("push_rdy", {31'b0, s_ready}, 32'd1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_grant(input string tag, input int k, input logic [31:0] data);
    int n = 0;
    while (in_en == '0 && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_en"}, {8'b0, in_en}, 32'd1 << k);
    check({tag, "_io"}, {13'b0, io_in}, data);
    check({tag, "_st"}, {30'b0, dbg_state}, {30'b0, ST_GRANT});
  endtask

  task automatic finish_serve(input int k);
    tick();
    set_req(k, 4'd0);
    tick();
    check("serve_idle", {30'b0, dbg_state}, {30'b0, ST_IDLE});
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    req_in  = '0;
    tick();
    tick();
    check("rst_io",    {13'b0, io_in}, 32'd0);
    check("rst_en",    {8'b0, in_en}, 32'd0);
    check("rst_lvl",   {27'b0, fifo_level}, 32'd0);
    check("rst_err",   {31'b0, err_timeout}, 32'd0);
    check("rst_rdy",   {31'b0, s_ready}, 32'd0);
    check("rst_st",    {30'b0, dbg_state}, {30'b0, ST_IDLE});
    rst_n = 1'b1;
    check("rdy_pre",   {31'b0, s_ready}, 32'd0);
    tick();
    check("rdy_post",  {31'b0, s_ready}, 32'd1);

    // Single request from core 5
    push(19'h3FFFF);
    check("one_lvl1", {27'b0, fifo_level}, 32'd1);
    set_req(5, 4'd1);
    wait_grant("one", 5, 32'h3FFFF);
    check("one_lvl0", {27'b0, fifo_level}, 32'd0);
    tick();
    tick();
    check("one_en_off", {8'b0, in_en}, 32'd0);
    check("one_wait",   {30'b0, dbg_state}, {30'b0, ST_WAIT});
    set_req(5, 4'd0);
    tick();
    check("one_idle",   {30'b0, dbg_state}, {30'b0, ST_IDLE});
    check("one_hold",   {13'b0, io_in}, 32'h3FFFF);

    // Non-request code 3 on core 2
    push(19'h00ABC);
    set_req(2, 4'd3);
    tick();
    tick();
    tick();
    check("nr_en",  {8'b0, in_en}, 32'd0);
    check("nr_lvl", {27'b0, fifo_level}, 32'd1);
    check("nr_st",  {30'b0, dbg_state}, {30'b0, ST_IDLE});
    set_req(2, 4'd1);
    wait_grant("nr_serve", 2, 32'h00ABC);
    finish_serve(2);

    // Timeout on core 3, then core 4 wins, then core 3 again
    push(19'h00111);
    set_req(3, 4'd1);
    wait_grant("to_g3", 3, 32'h00111);
    set_req(4, 4'd1);
    push(19'h00222);
    check("to_ignore", {8'b0, in_en}, 32'd0);
    for (int i = 0; i < 14; i++) tick();
    check("to_err_pre", {31'b0, err_timeout}, 32'd0);
    check("to_st_pre",  {30'b0, dbg_state}, {30'b0, ST_WAIT});
    tick();
    check("to_err",     {31'b0, err_timeout}, 32'd1);
    check("to_st",      {30'b0, dbg_state}, {30'b0, ST_IDLE});
    wait_grant("to_g4", 4, 32'h00222);
    finish_serve(4);
    tick();
    tick();
    check("empty_no_en", {8'b0, in_en}, 32'd0);
    check("empty_idle",  {30'b0, dbg_state}, {30'b0, ST_IDLE});
    check("err_sticky",  {31'b0, err_timeout}, 32'd1);
    push(19'h00333);
    wait_grant("to_back3", 3, 32'h00333);
    finish_serve(3);

    // Reset during WAIT with 5 samples buffered
    for (int i = 0; i < 6; i++) push(19'(32'h200 + i));
    set_req(0, 4'd1);
    wait_grant("mr_pre", 0, 32'h200);
    tick();
    check("mr_lvl5", {27'b0, fifo_level}, 32'd5);
    check("mr_wait", {30'b0, dbg_state}, {30'b0, ST_WAIT});
    #2 rst_n = 1'b0;
    #1;
    check("mr_lvl", {27'b0, fifo_level}, 32'd0);
    check("mr_io",  {13'b0, io_in}, 32'd0);
    check("mr_en",  {8'b0, in_en}, 32'd0);
    check("mr_st",  {30'b0, dbg_state}, {30'b0, ST_IDLE});
    check("mr_err", {31'b0, err_timeout}, 32'd0);
    check("mr_rdy", {31'b0, s_ready}, 32'd0);
    tick();
    tick();
    check("mr_no_pulse", {8'b0, in_en}, 32'd0);
    set_req(0, 4'd0);
    rst_n = 1'b1;
    tick();
    check("mr_rdy_back", {31'b0, s_ready}, 32'd1);
    push(19'h12345);
    set_req(23, 4'd1);
    wait_grant("mr_after", 23, 32'h12345);
    finish_serve(23);

    // All 24 cores requesting, 48 samples, two full rounds
    for (int k = 0; k < NC; k++) set_req(k, 4'd1);
    fork
      begin
        for (int n = 0; n < 48; n++) push(19'(n));
      end
      begin
        for (int n = 0; n < 48; n++) begin
          wait_grant("rr", n % NC, 32'(n));
          tick();
          set_req(n % NC, 4'd0);
          tick();
          set_req(n % NC, 4'd1);
        end
      end
    join
    req_in = '0;
    tick();
    check("rr_lvl", {27'b0, fifo_level}, 32'd0);
    check("rr_err", {31'b0, err_timeout}, 32'd0);

    // Full FIFO: 17th sample held until a pop, then drain in order
    for (int i = 0; i < 16; i++) begin
      push(19'(100 + i));
      exp_q.push_back(32'(100 + i));
    end
    check("full_lvl", {27'b0, fifo_level}, 32'd16);
    check("full_rdy", {31'b0, s_ready}, 32'd0);
    s_data  = 19'd116;
    s_valid = 1'b1;
    tick();
    tick();
    check("full_hold", {27'b0, fifo_level}, 32'd16);
    set_req(10, 4'd1);
    wait_grant("full_pop", 10, exp_q.pop_front());
    check("full_lvl15", {27'b0, fifo_level}, 32'd15);
    tick();
    check("full_refill", {27'b0, fifo_level}, 32'd16);
    s_valid = 1'b0;
    exp_q.push_back(32'd116);
    set_req(10, 4'd0);
    tick();
    for (int i = 0; i < 16; i++) begin
      set_req(10, 4'd1);
      wait_grant("drain", 10, exp_q.pop_front());
      finish_serve(10);
    end
    check("drain_lvl", {27'b0, fifo_level}, 32'd0);
    check("drain_q",   32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
